// File: rtl/timer_controller.sv
// timer_controller: countdown timer sequencer (IDLE/RUN/PAUSE/ALARM); TIMER_CTRL_DEBOUNCE_EN adds button debounce
module timer_controller #(
  parameter int TICK_HZ     = 100,
  parameter int BUZZ_TICKS  = 300,
  parameter int BLINK_TICKS = 50,
  parameter int DB_CYCLES   = 250000
) (
  input  logic        clockIn,
  input  logic        resetN,
  input  logic        tick,
  input  logic        toneClk,
  input  logic        button0,
  input  logic        button1,
  input  logic [9:0]  switches,
  output logic [19:0] value,
  output logic        running,
  output logic        expired,
  output logic        blink,
  output logic        buzzer
);
  localparam int AW = $clog2(BUZZ_TICKS + 1);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  if (TICK_HZ < 1 || BUZZ_TICKS < 1 || BLINK_TICKS < 1 || DB_CYCLES < 1) begin : g_bad_param
    $error("timer_controller: all parameters must be >= 1");
  end
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;
  state_t state_q, state_d;
  logic [1:0] pins, lvl, press, prev_q, prev_d;
  logic [1:0][1:0] sync_q, sync_d;
  logic start, load;
  logic [19:0] value_q, value_d, preset;
  logic [AW-1:0] alarm_q, alarm_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic blink_q, blink_d, running_q, running_d, expired_q, expired_d;
  assign pins   = {button1, button0};
  assign press  = prev_q & ~lvl;
  assign start  = press[0];
  assign load   = press[1];
  assign preset = 20'(switches) * 20'(TICK_HZ);
  // two-flop synchronizers and previous-level capture for falling-edge detection
  always_comb begin
    for (int i = 0; i < 2; i++) sync_d[i] = {sync_q[i][0], pins[i]};
    prev_d = lvl;
  end
  // synchronizer and edge-detect registers; released (high) level after reset
  always_ff @(posedge clockIn) begin
    if (!resetN) begin
      sync_q <= '1;
      prev_q <= '1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DB_CYCLES + 1);
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0] db_q, db_d;
  assign lvl = db_q;
  // debounced level flips only after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = (sync_q[i][1] == db_q[i]) ? '0 : cnt_q[i] + 1'b1;
      if (cnt_d[i] == DW'(DB_CYCLES)) begin
        cnt_d[i] = '0;
        db_d[i]  = ~db_q[i];
      end
    end
  end
  // debounce counters and debounced levels
  always_ff @(posedge clockIn) begin
    if (!resetN) begin
      cnt_q <= '0;
      db_q  <= '1;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end
`else
  assign lvl = {sync_q[1][1], sync_q[0][1]};
`endif
  // next state, remaining time and alarm/blink sequencing; load beats start, expiry beats pause
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    alarm_d = alarm_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    case (state_q)
      IDLE: begin
        if (load) value_d = preset;
        else if (start && value_q != '0) state_d = RUN;
      end
      RUN: begin
        if (load) begin
          state_d = IDLE;
          value_d = preset;
        end else begin
          if (tick && value_q != '0) value_d = value_q - 1'b1;
          state_d = (tick && value_q == 20'd1) ? ALARM : start ? PAUSE : RUN;
        end
      end
      PAUSE: begin
        if (load) begin
          state_d = IDLE;
          value_d = preset;
        end else if (start) state_d = RUN;
      end
      ALARM: begin
        if (load) begin
          state_d = IDLE;
          value_d = preset;
        end else if (start) begin
          state_d = IDLE;
          value_d = '0;
        end else if (tick) begin
          alarm_d = alarm_q + 1'b1;
          bcnt_d  = (bcnt_q == BW'(BLINK_TICKS - 1)) ? '0 : bcnt_q + 1'b1;
          blink_d = (bcnt_q == BW'(BLINK_TICKS - 1)) ? ~blink_q : blink_q;
          if (alarm_q == AW'(BUZZ_TICKS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != ALARM || state_q != ALARM) begin
      alarm_d = '0;
      bcnt_d  = '0;
      blink_d = (state_d == ALARM);
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == ALARM);
  end
  // state register
  always_ff @(posedge clockIn) begin
    if (!resetN) state_q <= IDLE;
    else state_q <= state_d;
  end
  // datapath and registered status outputs
  always_ff @(posedge clockIn) begin
    if (!resetN) begin
      value_q   <= '0;
      alarm_q   <= '0;
      bcnt_q    <= '0;
      blink_q   <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      alarm_q   <= alarm_d;
      bcnt_q    <= bcnt_d;
      blink_q   <= blink_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end
  assign value   = value_q;
  assign running = running_q;
  assign expired = expired_q;
  assign blink   = blink_q;
  assign buzzer  = toneClk & expired_q;
endmodule

// File: tb/tb_timer_controller.sv
// tb_timer_controller: randomized bench for timer_controller against a behavioural model
module tb_timer_controller;
  localparam int TICK_HZ = 100;
  localparam int BUZZ    = 4;
  localparam int BLINK   = 2;
  localparam int DB      = 8;
`ifdef TIMER_CTRL_DEBOUNCE_EN
  localparam int NLOW = DB;
  localparam int LAT  = 3;
`else
  localparam int NLOW = 1;
  localparam int LAT  = 2;
`endif
  logic clk = 0, rst_n = 0, tick = 0, tone = 0, b0 = 1, b1 = 1;
  logic [9:0] sw = '0;
  logic [19:0] value;
  logic running, expired, blink, buzzer;
  timer_controller #(.TICK_HZ(TICK_HZ), .BUZZ_TICKS(BUZZ), .BLINK_TICKS(BLINK), .DB_CYCLES(DB)) dut (
    .clockIn(clk), .resetN(rst_n), .tick(tick), .toneClk(tone), .button0(b0), .button1(b1),
    .switches(sw), .value(value), .running(running), .expired(expired), .blink(blink), .buzzer(buzzer)
  );
  always #5 clk = ~clk;
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mode_t;
  mode_t m_mode = M_IDLE;
  int m_value = 0, m_at = 0, edge_n = 0, run0 = 0, run1 = 0;
  bit due0[int];
  bit due1[int];
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic compare();
    check("value", 32'(value), m_value);
    check("running", 32'(running), 32'(m_mode == M_RUN));
    check("expired", 32'(expired), 32'(m_mode == M_ALARM));
    check("blink", 32'(blink), 32'(m_mode == M_ALARM && (m_at / BLINK) % 2 == 0));
    check("buzzer", 32'(buzzer), 32'(tone && m_mode == M_ALARM));
  endtask
  task automatic model_step(input bit st, input bit ld, input bit tk);
    int pre = int'(sw) * TICK_HZ;
    case (m_mode)
      M_IDLE: if (ld) m_value = pre; else if (st && m_value != 0) m_mode = M_RUN;
      M_RUN: begin
        if (ld) begin
          m_mode = M_IDLE;
          m_value = pre;
        end else begin
          if (tk) m_value--;
          if (m_value == 0) begin
            m_mode = M_ALARM;
            m_at = 0;
          end else if (st) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (ld) begin
          m_mode = M_IDLE;
          m_value = pre;
        end else if (st) m_mode = M_RUN;
      end
      M_ALARM: begin
        if (ld) begin
          m_mode = M_IDLE;
          m_value = pre;
        end else if (st) begin
          m_mode = M_IDLE;
          m_value = 0;
        end else if (tk) begin
          m_at++;
          if (m_at == BUZZ) m_mode = M_IDLE;
        end
      end
    endcase
  endtask
  task automatic cyc(input bit tk, input bit p0, input bit p1);
    compare();
    tick = tk;
    b0 = ~p0;
    b1 = ~p1;
    tone = 1'($urandom % 2);
    run0 = p0 ? run0 + 1 : 0;
    run1 = p1 ? run1 + 1 : 0;
    if (run0 == NLOW) due0[edge_n + LAT] = 1;
    if (run1 == NLOW) due1[edge_n + LAT] = 1;
    model_step(due0.exists(edge_n) != 0, due1.exists(edge_n) != 0, tk);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask
  task automatic idle(input int n, input int pct);
    repeat (n) cyc(($urandom % 100) < pct, 0, 0);
  endtask
  task automatic press(input bit p0, input bit p1, input int pct, input int hold);
    repeat (hold) cyc(($urandom % 100) < pct, p0, p1);
    idle(NLOW + 6, pct);
  endtask
  task automatic do_reset(input bit held);
    rst_n = 0;
    b0 = ~held;
    b1 = ~held;
    tick = 0;
    tone = 1;
    repeat (3) begin
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      check("rst_value", 32'(value), 0);
      check("rst_running", 32'(running), 0);
      check("rst_expired", 32'(expired), 0);
      check("rst_blink", 32'(blink), 0);
      check("rst_buzzer", 32'(buzzer), 0);
    end
    rst_n = 1;
    b0 = 1;
    b1 = 1;
    m_mode = M_IDLE;
    m_value = 0;
    m_at = 0;
    run0 = 0;
    run1 = 0;
    due0.delete();
    due1.delete();
  endtask
  initial begin
    @(negedge clk);
    do_reset(1);
    idle(5, 50);
    press(1, 0, 0, NLOW);
    check("start_at_zero", 32'(running), 0);
    sw = 10'd3;
    press(0, 1, 0, NLOW);
    check("load_300", 32'(value), 300);
    press(1, 0, 0, 12);
    check("held_start_once", 32'(running), 1);
    idle(10, 100);
    check("run_10_ticks", 32'(value), 290);
    press(1, 0, 0, NLOW);
    check("paused", 32'(running), 0);
    idle(20, 100);
    check("pause_hold", 32'(value), 290);
    press(1, 0, 0, NLOW);
    idle(1, 100);
    check("resume", 32'(value), 289);
    idle(289, 100);
    check("expiry_flag", 32'(expired), 1);
    check("expiry_value", 32'(value), 0);
    check("expiry_blink", 32'(blink), 1);
    idle(2, 100);
    check("blink_off", 32'(blink), 0);
    idle(2, 100);
    check("alarm_done", 32'(expired), 0);
    check("alarm_done_buzz", 32'(buzzer), 0);
    sw = 10'd3;
    press(0, 1, 0, NLOW);
    press(1, 0, 0, NLOW);
    idle(5, 100);
    sw = 10'd5;
    press(1, 1, 0, NLOW);
    check("load_wins_value", 32'(value), 500);
    check("load_wins_run", 32'(running), 0);
    sw = 10'd1;
    press(0, 1, 0, NLOW);
    press(1, 0, 0, NLOW);
    idle(100, 100);
    check("alarm_100", 32'(expired), 1);
    idle(1, 100);
    do_reset(0);
    check("reset_alarm_value", 32'(value), 0);
`ifdef TIMER_CTRL_DEBOUNCE_EN
    sw = 10'd7;
    repeat (5) cyc(0, 0, 1);
    idle(NLOW + 6, 0);
    check("glitch_no_load", 32'(value), 0);
    press(0, 1, 0, 12);
    check("debounced_load", 32'(value), 700);
`endif
    for (int i = 0; i < 3000; i++) begin
      int r = int'($urandom % 1000);
      int pct = int'($urandom_range(100, 40));
      if (r < 10) press(1, 0, pct, NLOW + int'($urandom % 3));
      else if (r < 16) begin
        sw = 10'($urandom % 2);
        press(0, 1, pct, NLOW + int'($urandom % 3));
      end else if (r < 18) press(1, 1, pct, NLOW + int'($urandom % 3));
      else if (r < 19) do_reset(0);
      else if (r < 25) begin
        sw = 10'($urandom % 1024);
        idle(1, pct);
      end else idle(1, pct);
    end
    compare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
